// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
// Module      : button_reader
// Description : Synchronises and debounces two raw push buttons (up/down) on
//               a shared slow sampling tick, emits one-clock press pulses and
//               maintains an 8-bit up/down press counter for an LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
module button_reader #(
    parameter int TICK_CYCLES  = 500000,
    parameter int STABLE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       up_level,
    output logic       down_level,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [7:0] value
);

    localparam logic [25:0] c_tick_last = 26'(TICK_CYCLES - 1);
    localparam logic [3:0]  c_stable    = 4'(STABLE_TICKS);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait_hi = 2'd1;
    localparam logic [1:0] c_st_pressed = 2'd2;
    localparam logic [1:0] c_st_wait_lo = 2'd3;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]  w_btn;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [25:0] r_presc;
    logic        w_tick;
    logic [1:0]  w_level;
    logic [1:0]  w_pulse;
    logic [7:0]  r_value;

    assign w_btn = {btn_down, btn_up};

    // Two-flop synchroniser per button; only the second stage is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Shared free-running prescaler producing the sampling tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= 26'd0;
        end else if (r_presc == c_tick_last) begin
            r_presc <= 26'd0;
        end else begin
            r_presc <= r_presc + 26'd1;
        end
    end

    assign w_tick = (r_presc == c_tick_last);

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0] r_state;
        logic [3:0] r_scnt;
        logic       r_level;
        logic       r_pulse;
        logic       w_sync;
        logic [3:0] w_scnt_inc;

        assign w_sync     = r_sync2[gi];
        assign w_scnt_inc = r_scnt + 4'd1;

        // Debounce FSM: a level must persist for STABLE_TICKS samples; level
        // tracks PRESSED/WAIT_LO and the pulse fires only on WAIT_HI -> PRESSED.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= c_st_idle;
                r_scnt  <= 4'd0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_tick) begin
                    case (r_state)
                        c_st_idle: begin
                            if (w_sync) begin
                                r_state <= c_st_wait_hi;
                                r_scnt  <= 4'd1;
                            end
                        end
                        c_st_wait_hi: begin
                            if (!w_sync) begin
                                r_state <= c_st_idle;
                                r_scnt  <= 4'd0;
                            end else if (w_scnt_inc == c_stable) begin
                                r_state <= c_st_pressed;
                                r_scnt  <= 4'd0;
                                r_level <= 1'b1;
                                r_pulse <= 1'b1;
                            end else begin
                                r_scnt  <= w_scnt_inc;
                            end
                        end
                        c_st_pressed: begin
                            if (!w_sync) begin
                                r_state <= c_st_wait_lo;
                                r_scnt  <= 4'd1;
                            end
                        end
                        c_st_wait_lo: begin
                            if (w_sync) begin
                                // Bounce back to pressed: still the same press, no pulse.
                                r_state <= c_st_pressed;
                                r_scnt  <= 4'd0;
                            end else if (w_scnt_inc == c_stable) begin
                                r_state <= c_st_idle;
                                r_scnt  <= 4'd0;
                                r_level <= 1'b0;
                            end else begin
                                r_scnt  <= w_scnt_inc;
                            end
                        end
                        default: begin
                            r_state <= c_st_idle;
                            r_scnt  <= 4'd0;
                            r_level <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign w_level[gi] = r_level;
        assign w_pulse[gi] = r_pulse;
    end

    // Press counter: up and down in the same cycle cancel each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 8'h00;
        end else begin
            case (w_pulse)
                2'b01:   r_value <= r_value + 8'd1;
                2'b10:   r_value <= r_value - 8'd1;
                default: r_value <= r_value;
            endcase
        end
    end

    assign up_level   = w_level[0];
    assign down_level = w_level[1];
    assign up_pulse   = w_pulse[0];
    assign down_pulse = w_pulse[1];
    assign value      = r_value;

endmodule
`default_nettype wire

// File: tb/tb_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_reader
// Description : Directed self-checking bench for button_reader with
//               TICK_CYCLES=4 and STABLE_TICKS=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_reader;

    localparam int TK = 4;
    localparam int ST = 3;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       up_level;
    logic       down_level;
    logic       up_pulse;
    logic       down_pulse;
    logic [7:0] value;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int up_cnt = 0;
    int down_cnt = 0;
    int up_edge = -1;
    int down_edge = -1;
    bit lvl_seen = 1'b0;

    button_reader #(
        .TICK_CYCLES (TK),
        .STABLE_TICKS(ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .up_level  (up_level),
        .down_level(down_level),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: advance past the edge, then account for pulses/levels.
    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
        if (up_pulse) begin
            up_cnt++;
            up_edge = ecount;
        end
        if (down_pulse) begin
            down_cnt++;
            down_edge = ecount;
        end
        if (up_level) lvl_seen = 1'b1;
    endtask

    task automatic step_to(input int e);
        while (ecount < e) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ecount = 0;
    endtask

    // Edge (counted from reset release) at which the level change is seen,
    // for an input change applied just after edge k.
    function automatic int qual_edge(input int k);
        int t;
        t = k + 3;
        while ((t % TK) != 0) t++;
        return t + TK * (ST - 1);
    endfunction

    task automatic press(input logic u, input logic d);
        btn_up   = u;
        btn_down = d;
        repeat (16) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (16) step();
    endtask

    initial begin
        int   k0;
        int   pe;
        int   base_up;
        int   base_dn;
        logic [7:0] v_exp;

        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with buttons toggling: everything stays zero.
        for (int i = 0; i < 5; i++) begin
            btn_up   = i[0];
            btn_down = ~i[0];
            step();
            chk("reset_hold", {24'd0, up_level, down_level, up_pulse, down_pulse, 4'd0} | {24'd0, value}, 32'd0);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rst      = 1'b0;
        ecount   = 0;
        #1;
        chk("reset_release_value", {24'd0, value}, 32'h00);
        step();
        chk("reset_after_outs", {28'd0, up_level, down_level, up_pulse, down_pulse}, 32'd0);

        // Clean press with exact latency, pulse width and release latency.
        do_reset();
        base_up = up_cnt;
        base_dn = down_cnt;
        step_to(2);
        k0 = ecount;
        btn_up = 1'b1;
        pe = qual_edge(k0);
        step_to(pe - 1);
        chk("press_pre_pulse", {31'd0, up_pulse}, 32'd0);
        chk("press_pre_level", {31'd0, up_level}, 32'd0);
        step_to(pe);
        chk("press_pulse", {31'd0, up_pulse}, 32'd1);
        chk("press_level", {31'd0, up_level}, 32'd1);
        chk("press_value_pre", {24'd0, value}, 32'h00);
        step();
        chk("press_pulse_end", {31'd0, up_pulse}, 32'd0);
        chk("press_value", {24'd0, value}, 32'h01);
        step_to(k0 + 40);
        btn_up = 1'b0;
        pe = qual_edge(ecount);
        step_to(pe - 1);
        chk("release_level_hold", {31'd0, up_level}, 32'd1);
        step_to(pe);
        chk("release_level_fall", {31'd0, up_level}, 32'd0);
        step_to(pe + 12);
        chk("press_up_count", up_cnt - base_up, 1);
        chk("press_down_count", down_cnt - base_dn, 0);
        chk("press_value_final", {24'd0, value}, 32'h01);

        // Bounce faster than qualification: nothing is accepted.
        do_reset();
        base_up  = up_cnt;
        lvl_seen = 1'b0;
        step();
        for (int i = 0; i < 36; i++) begin
            btn_up = (((i / 3) % 2) == 0);
            step();
        end
        btn_up = 1'b0;
        repeat (20) step();
        chk("bounce_pulses", up_cnt - base_up, 0);
        chk("bounce_level", {31'd0, lvl_seen}, 32'd0);
        chk("bounce_value", {24'd0, value}, 32'h00);

        // Wrap: one down press from zero, then 256 up presses.
        press(1'b0, 1'b1);
        chk("wrap_down", {24'd0, value}, 32'hFF);
        base_up = up_cnt;
        v_exp   = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            press(1'b1, 1'b0);
            v_exp = v_exp + 8'd1;
            chk("wrap_up_step", {24'd0, value}, {24'd0, v_exp});
            if (i == 0) chk("wrap_to_zero", {24'd0, value}, 32'h00);
        end
        chk("wrap_up_count", up_cnt - base_up, 256);
        chk("wrap_final", {24'd0, value}, 32'hFF);

        // Simultaneous press: both pulses together, value unchanged.
        do_reset();
        base_up = up_cnt;
        base_dn = down_cnt;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        repeat (40) step();
        chk("simul_up_count", up_cnt - base_up, 1);
        chk("simul_down_count", down_cnt - base_dn, 1);
        chk("simul_same_cycle", up_edge, down_edge);
        chk("simul_up_edge", up_edge, qual_edge(0));
        chk("simul_levels", {30'd0, up_level, down_level}, 32'd3);
        chk("simul_value", {24'd0, value}, 32'h00);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (20) step();

        // Reset while in WAIT_HI with the button held: full requalification.
        do_reset();
        base_up = up_cnt;
        btn_up  = 1'b1;
        step_to(6);
        chk("midrst_no_pulse", up_cnt - base_up, 0);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {24'd0, up_level, down_level, up_pulse, down_pulse, 4'd0} | {24'd0, value}, 32'd0);
        step();
        step();
        rst    = 1'b0;
        ecount = 0;
        pe = qual_edge(0);
        step_to(pe - 1);
        chk("midrst_pre_pulse", up_cnt - base_up, 0);
        step_to(pe);
        chk("midrst_pulse", {31'd0, up_pulse}, 32'd1);
        step();
        chk("midrst_value", {24'd0, value}, 32'h01);
        repeat (20) step();
        chk("midrst_count", up_cnt - base_up, 1);
        btn_up = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
